// File: rtl/maxnet_feeder.sv
// maxnet_feeder: gathers one frame of four binary32 activations, sanitises
// them, drives a Maxnet instance until it reports a winner or times out,
// then offers the winning value and status flags on a valid/ready port.
// Only one frame is ever in flight.

module maxnet_feeder #(
    parameter int N_INPUTS       = 4,
    parameter int WIDTH          = 32,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [WIDTH-1:0] cfg_epsilon,
    output logic [WIDTH-1:0] mx_num1,
    output logic [WIDTH-1:0] mx_num2,
    output logic [WIDTH-1:0] mx_num3,
    output logic [WIDTH-1:0] mx_num4,
    output logic [WIDTH-1:0] mx_epsilon,
    output logic             mx_start,
    input  logic             mx_done,
    input  logic [WIDTH-1:0] mx_max,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] res_data,
    output logic [2:0]       res_flags
);

    localparam int CNT_W = (N_INPUTS > 1) ? $clog2(N_INPUTS) : 1;
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N_INPUTS - 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_LOAD = 2'd0,
        ST_RUN  = 2'd1,
        ST_OUT  = 2'd2
    } state_e;

    // Result of cleaning one activation: the word to store plus the two
    // per-word flags (infinity clamped, NaN/negative zeroed).
    typedef struct packed {
        logic [WIDTH-1:0] word;
        logic             inf;
        logic             nan_neg;
    } san_t;

    // Negatives and NaNs become +0, +inf saturates to the largest finite
    // value; -0 is zeroed silently because it already equals zero in value.
    function automatic san_t sanitise(input logic [WIDTH-1:0] x);
        san_t r;
        r.word    = x;
        r.inf     = 1'b0;
        r.nan_neg = 1'b0;
        if (x[31]) begin
            r.word    = 32'h0000_0000;
            r.nan_neg = (x[30:0] != 31'd0);
        end else if ((x[30:23] == 8'hFF) && (x[22:0] != 23'd0)) begin
            r.word    = 32'h0000_0000;
            r.nan_neg = 1'b1;
        end else if (x[30:0] == 31'h7F80_0000) begin
            r.word = 32'h7F7F_FFFF;
            r.inf  = 1'b1;
        end else begin
            r.word = x;
        end
        return r;
    endfunction

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic [WIDTH-1:0] num_q [N_INPUTS];
    logic [WIDTH-1:0] num_d [N_INPUTS];
    logic [WIDTH-1:0] eps_q, eps_d;
    logic             in_ready_q, in_ready_d;
    logic             mx_start_q, mx_start_d;
    logic             res_valid_q, res_valid_d;
    logic [WIDTH-1:0] res_data_q, res_data_d;
    logic [2:0]       flags_q, flags_d;
    san_t             san_s;

    // Next-state and next-output computation for the LOAD/RUN/OUT sequencer.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        tmo_d       = tmo_q;
        num_d       = num_q;
        eps_d       = eps_q;
        in_ready_d  = in_ready_q;
        mx_start_d  = mx_start_q;
        res_valid_d = res_valid_q;
        res_data_d  = res_data_q;
        flags_d     = flags_q;
        san_s       = sanitise(in_data);

        case (state_q)
            ST_LOAD: begin
                if (in_valid && in_ready_q) begin
                    num_d[cnt_q] = san_s.word;
                    if (cnt_q == {CNT_W{1'b0}}) begin
                        // First word of a frame: fresh epsilon, fresh flags.
                        eps_d   = cfg_epsilon;
                        flags_d = {1'b0, san_s.inf, san_s.nan_neg};
                    end else begin
                        flags_d = flags_q | {1'b0, san_s.inf, san_s.nan_neg};
                    end
                    if (cnt_q == CNT_LAST) begin
                        cnt_d      = {CNT_W{1'b0}};
                        tmo_d      = {TMO_W{1'b0}};
                        state_d    = ST_RUN;
                        in_ready_d = 1'b0;
                        mx_start_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end else begin
                    cnt_d = cnt_q;
                end
            end

            ST_RUN: begin
                if (mx_done) begin
                    // A finished Maxnet beats a simultaneous timeout.
                    res_data_d  = mx_max;
                    state_d     = ST_OUT;
                    mx_start_d  = 1'b0;
                    res_valid_d = 1'b1;
                end else if (tmo_q == TMO_LAST) begin
                    res_data_d  = 32'h0000_0000;
                    flags_d[2]  = 1'b1;
                    state_d     = ST_OUT;
                    mx_start_d  = 1'b0;
                    res_valid_d = 1'b1;
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
            end

            ST_OUT: begin
                if (res_ready) begin
                    state_d     = ST_LOAD;
                    res_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                    tmo_d       = {TMO_W{1'b0}};
                end else begin
                    res_valid_d = 1'b1;
                end
            end

            default: begin
                state_d     = ST_LOAD;
                cnt_d       = {CNT_W{1'b0}};
                tmo_d       = {TMO_W{1'b0}};
                in_ready_d  = 1'b1;
                mx_start_d  = 1'b0;
                res_valid_d = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_LOAD;
            cnt_q       <= {CNT_W{1'b0}};
            tmo_q       <= {TMO_W{1'b0}};
            for (int i = 0; i < N_INPUTS; i++) begin
                num_q[i] <= {WIDTH{1'b0}};
            end
            eps_q       <= {WIDTH{1'b0}};
            in_ready_q  <= 1'b1;
            mx_start_q  <= 1'b0;
            res_valid_q <= 1'b0;
            res_data_q  <= {WIDTH{1'b0}};
            flags_q     <= 3'b000;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            tmo_q       <= tmo_d;
            num_q       <= num_d;
            eps_q       <= eps_d;
            in_ready_q  <= in_ready_d;
            mx_start_q  <= mx_start_d;
            res_valid_q <= res_valid_d;
            res_data_q  <= res_data_d;
            flags_q     <= flags_d;
        end
    end

    assign in_ready   = in_ready_q;
    assign mx_num1    = num_q[0];
    assign mx_num2    = num_q[1];
    assign mx_num3    = num_q[2];
    assign mx_num4    = num_q[3];
    assign mx_epsilon = eps_q;
    assign mx_start   = mx_start_q;
    assign res_valid  = res_valid_q;
    assign res_data   = res_data_q;
    assign res_flags  = flags_q;

endmodule

// File: tb/tb_maxnet_feeder.sv
// Bench for maxnet_feeder: frame-level behavioural model, per-cycle compare,
// directed frames with literal expectations and a randomised frame loop.

module tb_maxnet_feeder;

    localparam int T = 20;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_data = 32'h0;
    logic [31:0] cfg_epsilon = 32'h0;
    logic [31:0] mx_num1, mx_num2, mx_num3, mx_num4, mx_epsilon;
    logic        mx_start;
    logic        mx_done = 1'b0;
    logic [31:0] mx_max = 32'h0;
    logic        res_valid;
    logic        res_ready = 1'b0;
    logic [31:0] res_data;
    logic [2:0]  res_flags;

    always #5 clk = ~clk;

    maxnet_feeder #(.N_INPUTS(4), .WIDTH(32), .TIMEOUT_CYCLES(T)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .cfg_epsilon(cfg_epsilon),
        .mx_num1(mx_num1), .mx_num2(mx_num2), .mx_num3(mx_num3), .mx_num4(mx_num4),
        .mx_epsilon(mx_epsilon), .mx_start(mx_start), .mx_done(mx_done),
        .mx_max(mx_max), .res_valid(res_valid), .res_ready(res_ready),
        .res_data(res_data), .res_flags(res_flags)
    );

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic wait_fail(input string name);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: wait expired at %0t", name, $time);
    endtask

    // ---------------- behavioural model ----------------
    // phase: 0 collecting words, 1 Maxnet running, 2 result offered
    int          m_phase = 0;
    int          m_run = 0;
    logic [33:0] m_q[$];
    logic [31:0] m_words[4];
    logic [31:0] m_eps = 32'h0;
    logic [31:0] m_res = 32'h0;
    logic [2:0]  m_flags = 3'b000;

    // returns {inf_clamped, nan_or_neg, stored_word}
    function automatic logic [33:0] m_san(input logic [31:0] x);
        if (x == 32'h8000_0000) return {2'b00, 32'h0};
        if (x[31]) return {2'b01, 32'h0};
        if (x[30:23] == 8'hFF) begin
            if (x[22:0] == 23'd0) return {2'b10, 32'h7F7F_FFFF};
            return {2'b01, 32'h0};
        end
        return {2'b00, x};
    endfunction

    task automatic model_step();
        logic [33:0] s;
        if (rst) begin
            m_phase = 0; m_run = 0; m_q.delete();
            foreach (m_words[i]) m_words[i] = 32'h0;
            m_eps = 32'h0; m_res = 32'h0; m_flags = 3'b000;
        end else begin
            case (m_phase)
                0: if (in_valid) begin
                    s = m_san(in_data);
                    if (m_q.size() == 0) m_eps = cfg_epsilon;
                    m_q.push_back(s);
                    m_words[m_q.size() - 1] = s[31:0];
                    if (m_q.size() == 4) begin
                        m_flags = 3'b000;
                        foreach (m_q[i]) m_flags[1:0] = m_flags[1:0] | m_q[i][33:32];
                        m_q.delete();
                        m_phase = 1;
                        m_run = 0;
                    end
                end
                1: begin
                    m_run++;
                    if (mx_done) begin
                        m_res = mx_max; m_phase = 2;
                    end else if (m_run == T) begin
                        m_res = 32'h0; m_flags[2] = 1'b1; m_phase = 2;
                    end
                end
                default: if (res_ready) m_phase = 0;
            endcase
        end
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    // Per-cycle compare of DUT against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            check("in_ready", {31'd0, in_ready}, 32'(m_phase == 0));
            check("mx_start", {31'd0, mx_start}, 32'(m_phase == 1));
            check("res_valid", {31'd0, res_valid}, 32'(m_phase == 2));
            check("mx_num1", mx_num1, m_words[0]);
            check("mx_num2", mx_num2, m_words[1]);
            check("mx_num3", mx_num3, m_words[2]);
            check("mx_num4", mx_num4, m_words[3]);
            check("mx_epsilon", mx_epsilon, m_eps);
            if (m_phase == 2) begin
                check("res_data", res_data, m_res);
                check("res_flags", {29'd0, res_flags}, {29'd0, m_flags});
            end
        end
    end

    // ---------------- Maxnet / consumer stub ----------------
    int          done_mode = 0;     // 0 random, 1 never, 2 always
    bit          use_fixed = 1'b0;
    logic [31:0] fixed_max = 32'h0;
    bit          hold_rr = 1'b0;
    bit          rr_force = 1'b0;

    initial forever begin
        @(posedge clk);
        #2;
        case (done_mode)
            1: mx_done = 1'b0;
            2: mx_done = 1'b1;
            default: mx_done = ($urandom_range(0, 15) == 0);
        endcase
        mx_max = use_fixed ? fixed_max : $urandom;
        res_ready = rr_force ? 1'b1 : (hold_rr ? 1'b0 : ($urandom_range(0, 2) == 0));
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_word(input logic [31:0] w, input logic [31:0] eps);
        bit ok = 1'b0;
        int budget = 200;
        repeat ($urandom_range(0, 2)) tick();
        in_valid = 1'b1; in_data = w; cfg_epsilon = eps;
        while (!ok && budget > 0) begin
            @(negedge clk);
            ok = in_ready;
            tick();
            budget--;
        end
        in_valid = 1'b0; cfg_epsilon = $urandom;
        if (!ok) wait_fail("accept_wait");
    endtask

    task automatic send_frame(input logic [31:0] w0, input logic [31:0] w1,
                              input logic [31:0] w2, input logic [31:0] w3,
                              input logic [31:0] eps);
        send_word(w0, eps);
        send_word(w1, $urandom);
        send_word(w2, $urandom);
        send_word(w3, $urandom);
    endtask

    task automatic wait_res_valid();
        int b = 0;
        @(negedge clk);
        while (!res_valid && b < 400) begin
            @(negedge clk);
            b++;
        end
        if (!res_valid) wait_fail("res_valid_wait");
    endtask

    task automatic wait_in_ready();
        int b = 0;
        @(negedge clk);
        while (!in_ready && b < 400) begin
            @(negedge clk);
            b++;
        end
        if (!in_ready) wait_fail("in_ready_wait");
        tick();
    endtask

    function automatic logic [31:0] rand_word();
        case ($urandom_range(0, 7))
            0: return 32'h7F80_0000;
            1: return 32'h8000_0000;
            2: return 32'hFF80_0000;
            3: return {1'b0, 8'hFF, 23'($urandom_range(1, 100000))};
            4: return $urandom & 32'h807F_FFFF;
            5: return 32'h0000_0000;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- main sequence ----------------
    initial begin
        int run_len;
        rst = 1'b1;
        repeat (2) tick();
        chk_en = 1'b1;
        @(negedge clk);
        check("rst_in_ready", {31'd0, in_ready}, 32'h1);
        check("rst_res_data", res_data, 32'h0);
        check("rst_flags", {29'd0, res_flags}, 32'h0);
        tick();
        rst = 1'b0;
        tick();

        // 1: clean frame, done immediately
        done_mode = 2; use_fixed = 1'b1; fixed_max = 32'h3FD9_999A;
        send_frame(32'h3ECC_CCCD, 32'h3FCC_CCCD, 32'h3FD9_999A, 32'h3FA6_6666, 32'hBE99_999A);
        check("t1_start", {31'd0, mx_start}, 32'h1);
        wait_res_valid();
        check("t1_res", res_data, 32'h3FD9_999A);
        check("t1_flags", {29'd0, res_flags}, 32'h0);
        check("t1_eps", mx_epsilon, 32'hBE99_999A);
        check("t1_num1", mx_num1, 32'h3ECC_CCCD);
        wait_in_ready();

        // 2: negative, NaN, -0, 1.0
        send_frame(32'hBF80_0000, 32'h7FC0_0000, 32'h8000_0000, 32'h3F80_0000, 32'hBD00_0000);
        wait_res_valid();
        check("t2_num1", mx_num1, 32'h0);
        check("t2_num2", mx_num2, 32'h0);
        check("t2_num3", mx_num3, 32'h0);
        check("t2_num4", mx_num4, 32'h3F80_0000);
        check("t2_flags", {29'd0, res_flags}, 32'h1);
        wait_in_ready();

        // 3: +inf clamp, then a clean frame reports no flags
        send_frame(32'h3F80_0000, 32'h4000_0000, 32'h7F80_0000, 32'h3F00_0000, 32'hBD00_0000);
        wait_res_valid();
        check("t3_num3", mx_num3, 32'h7F7F_FFFF);
        check("t3_flags", {29'd0, res_flags}, 32'h2);
        wait_in_ready();
        send_frame(32'h3F80_0000, 32'h0000_0001, 32'h0000_0000, 32'h3F00_0000, 32'hBD00_0000);
        wait_res_valid();
        check("t3b_flags", {29'd0, res_flags}, 32'h0);
        check("t3b_num2", mx_num2, 32'h0000_0001);
        wait_in_ready();

        // 4: timeout
        done_mode = 1;
        send_frame(32'h3F80_0000, 32'h4000_0000, 32'h4040_0000, 32'h4080_0000, 32'hBD00_0000);
        run_len = 0;
        @(negedge clk);
        while (mx_start && run_len < 200) begin
            run_len++;
            @(negedge clk);
        end
        check("t4_run_len", 32'(run_len), 32'(T));
        check("t4_valid", {31'd0, res_valid}, 32'h1);
        check("t4_res", res_data, 32'h0);
        check("t4_flags", {29'd0, res_flags}, 32'h4);
        wait_in_ready();

        // 5: consumer stalls, extra words must not be taken
        done_mode = 2; hold_rr = 1'b1; fixed_max = 32'h4120_0000;
        send_frame(32'h3F80_0000, 32'h4120_0000, 32'h4040_0000, 32'h4080_0000, 32'hBD00_0000);
        wait_res_valid();
        tick();
        in_valid = 1'b1; in_data = 32'h4220_0000;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("t5_in_ready", {31'd0, in_ready}, 32'h0);
            check("t5_res", res_data, 32'h4120_0000);
            tick();
        end
        in_valid = 1'b0;
        rr_force = 1'b1;
        tick();
        rr_force = 1'b0;
        @(negedge clk);
        check("t5_back_load", {31'd0, in_ready}, 32'h1);
        check("t5_valid_low", {31'd0, res_valid}, 32'h0);
        tick();
        hold_rr = 1'b0;

        // 6: reset after two words
        send_word(32'h4000_0000, 32'hBD00_0000);
        send_word(32'h4040_0000, 32'h0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        check("t6_in_ready", {31'd0, in_ready}, 32'h1);
        check("t6_start", {31'd0, mx_start}, 32'h0);
        check("t6_valid", {31'd0, res_valid}, 32'h0);
        check("t6_num1", mx_num1, 32'h0);
        tick();
        send_frame(32'h3E00_0000, 32'h3E80_0000, 32'h3F00_0000, 32'h3F40_0000, 32'hBC00_0000);
        wait_res_valid();
        check("t6_fresh_num1", mx_num1, 32'h3E00_0000);
        check("t6_fresh_num4", mx_num4, 32'h3F40_0000);
        wait_in_ready();

        // randomised frames
        done_mode = 0; use_fixed = 1'b0;
        for (int f = 0; f < 30; f++) begin
            send_frame(rand_word(), rand_word(), rand_word(), rand_word(), $urandom | 32'h8000_0000);
            wait_res_valid();
            wait_in_ready();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
